// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: link between the TAP controller and the DTM.
// The TAP side (master) drives the DR strobes, the active instruction and
// the retimed TDI. The DTM side (slave) returns its serial DR bit on dtm_tdo.
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH = 5
);
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic                tdi_o;
    logic [IR_WIDTH-1:0] ir_out;
    logic                dtm_tdo;

    modport master (
        output capture_dr,
        output shift_dr,
        output update_dr,
        output tdi_o,
        output ir_out,
        input  dtm_tdo
    );

    modport slave (
        input  capture_dr,
        input  shift_dr,
        input  update_dr,
        input  tdi_o,
        input  ir_out,
        output dtm_tdo
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller oversampling tck/tms/tdi in the
// clk domain. It runs the 16-state TAP FSM, owns the instruction register
// and emits single-clk DR strobes towards the DTM.
// Optional feature: define JTAG_TAP_TRST_EN to add the trst_n pin, which is
// synchronized and acts as a synchronous TAP reset independent of tck.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH    = 5,
    parameter logic [IR_WIDTH-1:0] IR_RESET    = {{(IR_WIDTH-1){1'b0}}, 1'b1},
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tck,
    input  logic                   tms,
    input  logic                   tdi,
`ifdef JTAG_TAP_TRST_EN
    input  logic                   trst_n,
`endif
    output logic                   tdo,
    output logic                   tdo_oe,
    output logic [3:0]             tap_state,
    jtag_tap_ctrl_if.master        dtm
);

    // Fewer than two stages would not be a synchronizer, so clamp.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Value loaded into the IR shift register in Capture-IR.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0, EX1_DR   = 4'h1, SH_DR    = 4'h2, PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
        EX2_IR   = 4'h8, EX1_IR   = 4'h9, SH_IR    = 4'hA, PAUSE_IR = 4'hB,
        RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
    } tap_state_e;

    logic [SYNC_N-1:0]   tck_sync_q;
    logic [SYNC_N-1:0]   tms_sync_q;
    logic [SYNC_N-1:0]   tdi_sync_q;
    logic                tck_d_q;
    logic                tck_s;
    logic                tms_s;
    logic                tdi_s;
    logic                rise;
    logic                fall;
    logic                trst_active;

    tap_state_e          state_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_out_q;
    logic                tdo_q;
    logic                tdo_oe_q;
    logic                capture_q;
    logic                shift_q;
    logic                update_q;

    // Pin synchronizers plus the delayed tck copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_d_q    <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_N-2:0], tck};
            tms_sync_q <= {tms_sync_q[SYNC_N-2:0], tms};
            tdi_sync_q <= {tdi_sync_q[SYNC_N-2:0], tdi};
            tck_d_q    <= tck_s;
        end
    end

    // tms/tdi come from the same stage as tck so they are coherent with it.
    assign tck_s = tck_sync_q[SYNC_N-1];
    assign tms_s = tms_sync_q[SYNC_N-1];
    assign tdi_s = tdi_sync_q[SYNC_N-1];
    assign rise  = tck_s & ~tck_d_q;
    assign fall  = ~tck_s & tck_d_q;

`ifdef JTAG_TAP_TRST_EN
    logic [1:0] trst_sync_q;

    // Two-flop synchronizer for the optional TAP reset pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trst_sync_q <= 2'b00;
        end else begin
            trst_sync_q <= {trst_sync_q[0], trst_n};
        end
    end

    assign trst_active = ~trst_sync_q[1];
`else
    assign trst_active = 1'b0;
`endif

    // Standard 1149.1 state graph, evaluated on each synchronized tck rise.
    function automatic tap_state_e next_state(input tap_state_e s, input logic t);
        case (s)
            TLR:      return t ? TLR    : RTI;
            RTI:      return t ? SEL_DR : RTI;
            SEL_DR:   return t ? SEL_IR : CAP_DR;
            CAP_DR:   return t ? EX1_DR : SH_DR;
            SH_DR:    return t ? EX1_DR : SH_DR;
            EX1_DR:   return t ? UPD_DR : PAUSE_DR;
            PAUSE_DR: return t ? EX2_DR : PAUSE_DR;
            EX2_DR:   return t ? UPD_DR : SH_DR;
            UPD_DR:   return t ? SEL_DR : RTI;
            SEL_IR:   return t ? TLR    : CAP_IR;
            CAP_IR:   return t ? EX1_IR : SH_IR;
            SH_IR:    return t ? EX1_IR : SH_IR;
            EX1_IR:   return t ? UPD_IR : PAUSE_IR;
            PAUSE_IR: return t ? EX2_IR : PAUSE_IR;
            EX2_IR:   return t ? UPD_IR : SH_IR;
            UPD_IR:   return t ? SEL_DR : RTI;
            default:  return TLR;
        endcase
    endfunction

    // TAP FSM with its IR, TDO and single-cycle DR strobes, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TLR;
            ir_shift_q <= '0;
            ir_out_q   <= IR_RESET;
            tdo_q      <= 1'b0;
            tdo_oe_q   <= 1'b0;
            capture_q  <= 1'b0;
            shift_q    <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;
            if (trst_active) begin
                state_q    <= TLR;
                ir_out_q   <= IR_RESET;
                ir_shift_q <= '0;
                tdo_oe_q   <= 1'b0;
            end else begin
                if (rise) begin
                    capture_q <= (state_q == CAP_DR);
                    shift_q   <= (state_q == SH_DR);
                    if (state_q == CAP_IR) begin
                        ir_shift_q <= IR_CAPTURE;
                    end else if (state_q == SH_IR) begin
                        ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                    end
                    state_q <= next_state(state_q, tms_s);
                end
                if (fall) begin
                    update_q <= (state_q == UPD_DR);
                    if (state_q == UPD_IR) begin
                        ir_out_q <= ir_shift_q;
                    end
                    if (state_q == SH_IR) begin
                        tdo_q    <= ir_shift_q[0];
                        tdo_oe_q <= 1'b1;
                    end else if (state_q == SH_DR) begin
                        tdo_q    <= dtm.dtm_tdo;
                        tdo_oe_q <= 1'b1;
                    end else begin
                        tdo_oe_q <= 1'b0;
                    end
                end
                if (state_q == TLR) begin
                    ir_out_q <= IR_RESET;
                end
            end
        end
    end

    assign tdo            = tdo_q;
    assign tdo_oe         = tdo_oe_q;
    assign tap_state      = state_q;
    assign dtm.capture_dr = capture_q;
    assign dtm.shift_dr   = shift_q;
    assign dtm.update_dr  = update_q;
    assign dtm.ir_out     = ir_out_q;
    assign dtm.tdi_o      = tdi_s;

endmodule
